// File: rtl/eth_framer_v2.sv
// Byte-wide Ethernet II transmit framer built around a single state machine.
// Define ETH_FRAMER_VLAN_EN to insert an 802.1Q tag (vlan_tci) after the source MAC.
module eth_framer_v2 #(
   parameter int PREAMBLE_OCTETS    = 7,
   parameter int MIN_PAYLOAD_OCTETS = 46,
   parameter int IFG_OCTETS         = 12
) (
   input  logic        clk,
   input  logic        sresetn,
   input  logic [47:0] src_mac,
   input  logic [47:0] dst_mac,
   input  logic [15:0] ethertype,
`ifdef ETH_FRAMER_VLAN_EN
   input  logic [15:0] vlan_tci,
`endif
   output logic        payload_axis_tready,
   input  logic        payload_axis_tvalid,
   input  logic        payload_axis_tlast,
   input  logic [7:0]  payload_axis_tdata,
   input  logic        out_axis_tready,
   output logic        out_axis_tvalid,
   output logic        out_axis_tlast,
   output logic [7:0]  out_axis_tdata
);

`ifdef ETH_FRAMER_VLAN_EN
   localparam int HDR_BYTES = 18;
`else
   localparam int HDR_BYTES = 14;
`endif
   localparam int          HDR_W    = HDR_BYTES * 8;
   localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_OCTETS - 1);
   localparam logic [15:0] IFG_LAST = 16'(IFG_OCTETS - 1);
   localparam logic [15:0] MIN_PAY  = 16'(MIN_PAYLOAD_OCTETS);

   typedef enum logic [3:0] {
      IDLE,
      PRE,
      SFD,
      DST,
      SRC,
`ifdef ETH_FRAMER_VLAN_EN
      VLAN,
`endif
      TYPE,
      PAYLOAD,
      PAD,
      FCS,
      IFG
   } state_t;

   state_t           state;
   state_t           seg_next;
   logic [15:0]      cnt;
   logic [15:0]      seg_last;
   logic [15:0]      pay_cnt;
   logic [15:0]      pay_inc;
   logic [31:0]      crc;
   logic [31:0]      crc_upd;
   logic [31:0]      fcs;
   logic [HDR_W-1:0] hdr;
   logic [7:0]       data_r;
   logic             valid_r;
   logic             last_r;
   logic             in_payload;
   logic             fire;
   logic             crc_en;

   // Reflected CRC-32 (poly 0x04C11DB7), one byte per call.
   function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'd0, b};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   assign in_payload          = (state == PAYLOAD);
   assign out_axis_tvalid     = in_payload ? payload_axis_tvalid : valid_r;
   assign out_axis_tdata      = in_payload ? payload_axis_tdata  : data_r;
   assign out_axis_tlast      = in_payload ? 1'b0 : last_r;
   assign payload_axis_tready = in_payload & out_axis_tready;

   assign fire    = out_axis_tvalid & out_axis_tready;
   assign crc_en  = fire & !(state inside {IDLE, PRE, SFD, FCS, IFG});
   assign crc_upd = crc_en ? crc_next(crc, out_axis_tdata) : crc;
   assign fcs     = ~crc_upd;
   assign pay_inc = (pay_cnt == 16'hFFFF) ? pay_cnt : pay_cnt + 16'd1;

   // Length and successor of each header segment.
   always_comb begin
      seg_last = 16'd5;
      seg_next = SRC;
      case (state)
         SRC: begin
            seg_last = 16'd5;
`ifdef ETH_FRAMER_VLAN_EN
            seg_next = VLAN;
`else
            seg_next = TYPE;
`endif
         end
`ifdef ETH_FRAMER_VLAN_EN
         VLAN: begin
            seg_last = 16'd3;
            seg_next = TYPE;
         end
`endif
         TYPE: begin
            seg_last = 16'd1;
            seg_next = PAYLOAD;
         end
         default: begin
            seg_last = 16'd5;
            seg_next = SRC;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!sresetn) begin
         state   <= IDLE;
         cnt     <= '0;
         pay_cnt <= '0;
         crc     <= '0;
         data_r  <= '0;
         valid_r <= 1'b0;
         last_r  <= 1'b0;
      end else begin
         crc <= crc_upd;
         case (state)
            IDLE: begin
               if (payload_axis_tvalid) begin
                  state   <= PRE;
                  cnt     <= '0;
                  pay_cnt <= '0;
                  crc     <= '1;
`ifdef ETH_FRAMER_VLAN_EN
                  hdr     <= {dst_mac, src_mac, 16'h8100, vlan_tci, ethertype};
`else
                  hdr     <= {dst_mac, src_mac, ethertype};
`endif
                  data_r  <= 8'h55;
                  valid_r <= 1'b1;
                  last_r  <= 1'b0;
               end
            end
            PRE: begin
               if (fire) begin
                  if (cnt == PRE_LAST) begin
                     state  <= SFD;
                     cnt    <= '0;
                     data_r <= 8'hD5;
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
            end
            SFD: begin
               if (fire) begin
                  state  <= DST;
                  cnt    <= '0;
                  data_r <= hdr[HDR_W-1 -: 8];
                  hdr    <= hdr << 8;
               end
            end
`ifdef ETH_FRAMER_VLAN_EN
            DST, SRC, VLAN, TYPE: begin
`else
            DST, SRC, TYPE: begin
`endif
               if (fire) begin
                  // hdr always holds the bytes still to be presented after data_r
                  if (!(state == TYPE && cnt == 16'd1)) begin
                     data_r <= hdr[HDR_W-1 -: 8];
                     hdr    <= hdr << 8;
                  end
                  if (cnt == seg_last) begin
                     state <= seg_next;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 16'd1;
                  end
               end
            end
            PAYLOAD: begin
               if (fire) begin
                  pay_cnt <= pay_inc;
                  if (payload_axis_tlast) begin
                     valid_r <= 1'b1;
                     cnt     <= '0;
                     if (pay_inc < MIN_PAY) begin
                        state  <= PAD;
                        data_r <= 8'h00;
                     end else begin
                        state  <= FCS;
                        data_r <= fcs[7:0];
                     end
                  end
               end
            end
            PAD: begin
               if (fire) begin
                  pay_cnt <= pay_inc;
                  if (pay_inc >= MIN_PAY) begin
                     state  <= FCS;
                     cnt    <= '0;
                     data_r <= fcs[7:0];
                  end
               end
            end
            FCS: begin
               if (fire) begin
                  if (cnt == 16'd3) begin
                     state   <= (IFG_OCTETS == 0) ? IDLE : IFG;
                     cnt     <= '0;
                     valid_r <= 1'b0;
                     last_r  <= 1'b0;
                  end else begin
                     cnt    <= cnt + 16'd1;
                     last_r <= (cnt == 16'd2);
                     case (cnt[1:0])
                        2'd0:    data_r <= fcs[15:8];
                        2'd1:    data_r <= fcs[23:16];
                        default: data_r <= fcs[31:24];
                     endcase
                  end
               end
            end
            IFG: begin
               if (cnt == IFG_LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
